// File: rtl/vc_dispatch_pkg.sv
// Shared encodings for the VC dispatch stage: FSM states, VC ids and helpers.
package vc_dispatch_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_id_t;

  // Only IDLE and ACTIVE may pop the main FIFO or write a VC.
  function automatic logic is_running(state_t s);
    return (s == ST_IDLE) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/vc_dispatch_if.sv
// Main-FIFO read side and shared VC write side of the dispatch stage.
interface vc_dispatch_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  main_empty;
  logic                  main_error;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  main_rd_enable;
  logic                  vc0_almost_full;
  logic                  vc1_almost_full;
  logic                  vc0_full;
  logic                  vc1_full;
  logic                  vc0_wr_enable;
  logic                  vc1_wr_enable;
  logic [DATA_WIDTH-1:0] vc_data;

  modport master (
    input  main_empty, main_error, main_data,
    input  vc0_almost_full, vc1_almost_full, vc0_full, vc1_full,
    output main_rd_enable, vc0_wr_enable, vc1_wr_enable, vc_data
  );

  modport slave (
    output main_empty, main_error, main_data,
    output vc0_almost_full, vc1_almost_full, vc0_full, vc1_full,
    input  main_rd_enable, vc0_wr_enable, vc1_wr_enable, vc_data
  );
endinterface

// File: rtl/vc_dispatch_fsm.sv
// Link bring-up FSM (RESET/INIT/IDLE/ACTIVE/ERROR); state and status flags
// are registered together so the flags always match the state output.
module vc_dispatch_fsm
  import vc_dispatch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   init,
  input  logic   main_error,
  input  logic   main_empty,
  input  logic   in_flight,
  input  logic   overflow,
  output state_t state,
  output logic   idle_out,
  output logic   active_out,
  output logic   error_out
);

  state_t nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_RESET:  nxt = ST_INIT;
      ST_INIT:   if (init) nxt = ST_IDLE;
      ST_IDLE,
      ST_ACTIVE: begin
        if (main_error || overflow)      nxt = ST_ERROR;
        else if (!main_empty || in_flight) nxt = ST_ACTIVE;
        else                             nxt = ST_IDLE;
      end
      ST_ERROR:  nxt = ST_ERROR;
      default:   nxt = ST_INIT;
    endcase
    // Dropping init overrides everything, including a sticky ERROR.
    if (!init) nxt = ST_INIT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RESET;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state      <= nxt;
      idle_out   <= (nxt == ST_IDLE);
      active_out <= (nxt == ST_ACTIVE);
      error_out  <= (nxt == ST_ERROR);
    end
  end

endmodule

// File: rtl/vc_dispatch.sv
// Pops the main FIFO into VC0/VC1 by selector bit, 2-cycle rd->wr latency; reads stall on
// any VC almost_full. Define VC_DISPATCH_COUNT_EN to add per-VC write counters.
module vc_dispatch
  import vc_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int VC_SEL_BIT = 5,
  parameter int UMBRAL_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_main_in,
  input  logic [UMBRAL_W-1:0] umbral_vc_in,
  vc_dispatch_if.master       bus,
  output logic [UMBRAL_W-1:0] umbral_main_out,
  output logic [UMBRAL_W-1:0] umbral_vc_out,
  output logic [STATE_W-1:0]  state,
  output logic                idle_out,
  output logic                active_out,
  output logic                error_out
`ifdef VC_DISPATCH_COUNT_EN
  ,
  output logic [7:0]          vc0_count,
  output logic [7:0]          vc1_count
`endif
);

  state_t                st;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] word;
  logic                  sel_vc1;
  logic                  live;
  logic                  write_due;
  logic                  overflow;
  logic                  write_ok;
  logic                  in_flight;
  logic                  issue;

  assign state   = st;
  assign word    = bus.main_data;
  assign sel_vc1 = (word[VC_SEL_BIT] == VC1);

  // live drops on the same edge the FSM leaves IDLE/ACTIVE, so reads stop and
  // in-flight words are discarded without waiting for the state to update.
  assign live      = is_running(st) && init && !bus.main_error;
  assign write_due = rd_valid_q && live;
  assign overflow  = write_due && (sel_vc1 ? bus.vc1_full : bus.vc0_full);
  assign write_ok  = write_due && !overflow;
  assign in_flight = bus.main_rd_enable || rd_valid_q;
  assign issue     = live && !overflow && !bus.main_empty &&
                     !bus.vc0_almost_full && !bus.vc1_almost_full;

  vc_dispatch_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .main_error (bus.main_error),
    .main_empty (bus.main_empty),
    .in_flight  (in_flight),
    .overflow   (overflow),
    .state      (st),
    .idle_out   (idle_out),
    .active_out (active_out),
    .error_out  (error_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.main_rd_enable <= 1'b0;
      rd_valid_q         <= 1'b0;
      bus.vc0_wr_enable  <= 1'b0;
      bus.vc1_wr_enable  <= 1'b0;
      bus.vc_data        <= '0;
      umbral_main_out    <= '0;
      umbral_vc_out      <= '0;
    end else begin
      bus.main_rd_enable <= issue;
      rd_valid_q         <= bus.main_rd_enable && live && !overflow;
      bus.vc0_wr_enable  <= write_ok && !sel_vc1;
      bus.vc1_wr_enable  <= write_ok && sel_vc1;
      bus.vc_data        <= write_ok ? word : '0;
      if (st == ST_INIT) begin
        umbral_main_out <= umbral_main_in;
        umbral_vc_out   <= umbral_vc_in;
      end
    end
  end

`ifdef VC_DISPATCH_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc0_count <= '0;
      vc1_count <= '0;
    end else if (st == ST_INIT) begin
      vc0_count <= '0;
      vc1_count <= '0;
    end else begin
      if (write_ok && !sel_vc1) vc0_count <= vc0_count + 8'd1;
      if (write_ok && sel_vc1)  vc1_count <= vc1_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_dispatch.sv
// Directed bench for vc_dispatch: behavioural main FIFO, scoreboard of expected VC writes.
module tb_vc_dispatch;
  import vc_dispatch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] umbral_main_in, umbral_vc_in;
  wire  [3:0] umbral_main_out, umbral_vc_out;
  wire  [2:0] state;
  wire        idle_out, active_out, error_out;
`ifdef VC_DISPATCH_COUNT_EN
  wire  [7:0] vc0_count, vc1_count;
`endif

  vc_dispatch_if #(.DATA_WIDTH(6)) bus ();

  vc_dispatch #(.DATA_WIDTH(6), .VC_SEL_BIT(5), .UMBRAL_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_main_in  (umbral_main_in),
    .umbral_vc_in    (umbral_vc_in),
    .bus             (bus),
    .umbral_main_out (umbral_main_out),
    .umbral_vc_out   (umbral_vc_out),
    .state           (state),
    .idle_out        (idle_out),
    .active_out      (active_out),
    .error_out       (error_out)
`ifdef VC_DISPATCH_COUNT_EN
    ,
    .vc0_count       (vc0_count),
    .vc1_count       (vc1_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       vc;
    logic [5:0] dat;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Main FIFO model: data appears the cycle after a pop strobe, 0 otherwise.
  logic [5:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n0 = 0, n1 = 0, base0 = 0, base1 = 0;

  assign bus.main_empty = (wr_ptr - rd_ptr - int'(bus.main_rd_enable)) <= 0;

  always @(posedge clk) begin
    if (bus.main_rd_enable && rd_ptr < wr_ptr) begin
      bus.main_data <= mem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end else begin
      bus.main_data <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [5:0] w, input bit expect_wr);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
    if (expect_wr) exp_q.push_back({w[5], w});
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_scoreboard_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.vc0_wr_enable || bus.vc1_wr_enable) begin
        check("wr_onehot", {31'd0, bus.vc0_wr_enable & bus.vc1_wr_enable}, 0);
        if (exp_q.size() == 0) begin
          check("wr_with_empty_scoreboard", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_vc", {31'd0, bus.vc1_wr_enable}, {31'd0, mon_e.vc});
          check("wr_dat", {26'd0, bus.vc_data}, {26'd0, mon_e.dat});
          if (bus.vc1_wr_enable) n1++;
          else n0++;
        end
      end else begin
        check("idle_vc_data", {26'd0, bus.vc_data}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; init = 1'b0;
    umbral_main_in = 4'd2; umbral_vc_in = 4'd2;
    bus.main_error = 1'b0;
    bus.vc0_almost_full = 1'b0; bus.vc1_almost_full = 1'b0;
    bus.vc0_full = 1'b0; bus.vc1_full = 1'b0;

    // Reset values
    #12;
    check("rst_state", state, 0);
    check("rst_rd", bus.main_rd_enable, 0);
    check("rst_wr", {bus.vc0_wr_enable, bus.vc1_wr_enable}, 0);
    check("rst_umbral", {umbral_main_out, umbral_vc_out}, 0);
    check("rst_flags", {idle_out, active_out, error_out}, 0);

    // Bring-up: RESET -> INIT, hold INIT, then IDLE
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    check("init_state", state, 1);
    check("init_umbral_main", umbral_main_out, 2);
    check("init_umbral_vc", umbral_vc_out, 2);
    init = 1'b1;
    @(negedge clk);
    check("idle_state", state, 2);
    check("idle_flag", idle_out, 1);

    // Single word to VC1, two-cycle latency
    push(6'b100101, 1'b1);
    @(negedge clk); check("single_rd_on", bus.main_rd_enable, 1);
    @(negedge clk); check("single_rd_off", bus.main_rd_enable, 0);
    drain(10);

    // Back-to-back stream; VC chosen by bit 5
    push(6'h01, 1'b1); push(6'h22, 1'b1); push(6'h03, 1'b1); push(6'h24, 1'b1);
    repeat (2) @(negedge clk);
    check("stream_state_active", state, 3);
    check("stream_active_flag", active_out, 1);
    drain(20);
    repeat (2) @(negedge clk);
    check("stream_state_idle", state, 2);

    // almost_full stalls reads; in-flight words still land
    for (int i = 0; i < 8; i++) push(6'h08 + 6'(i), 1'b1);
    repeat (3) @(negedge clk);
    bus.vc0_almost_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("afull_rd_stalled", bus.main_rd_enable, 0);
    end
    bus.vc0_almost_full = 1'b0;
    drain(30);

    // Overflow: word for full VC1 is dropped and FSM goes to ERROR
    bus.vc1_full = 1'b1;
    push(6'h2A, 1'b0);
    repeat (5) @(negedge clk);
    check("ovf_error_flag", error_out, 1);
    check("ovf_state", state, 4);
    push(6'h0B, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_rd_stopped", bus.main_rd_enable, 0);
    end
    wr_ptr = rd_ptr;
    bus.vc1_full = 1'b0;
    init = 1'b0;
    @(negedge clk);
    check("reinit_state", state, 1);
    check("reinit_error_clear", error_out, 0);
    init = 1'b1;
    @(negedge clk);
    check("reinit_idle", state, 2);
    base0 = n0; base1 = n1;

    // main_error while ACTIVE: ERROR next cycle, remaining words discarded
    for (int i = 0; i < 10; i++) push(6'h30 + 6'(i), 1'b1);
    repeat (4) @(negedge clk);
    check("merr_pre_state", state, 3);
    bus.main_error = 1'b1;
    @(negedge clk);
    check("merr_state", state, 4);
    check("merr_rd_off", bus.main_rd_enable, 0);
    bus.main_error = 1'b0;
    repeat (3) @(negedge clk);
    check("merr_sticky", state, 4);
    check("merr_rd_still_off", bus.main_rd_enable, 0);
`ifdef VC_DISPATCH_COUNT_EN
    check("cnt_vc0", vc0_count, n0 - base0);
    check("cnt_vc1", vc1_count, n1 - base1);
`endif
    exp_q.delete();
    wr_ptr = rd_ptr;

    // Asynchronous reset in the middle of a stream
    init = 1'b0;
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    check("pre_rst_idle", state, 2);
    for (int i = 0; i < 6; i++) push(6'h10 + 6'(i), 1'b1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_rd", bus.main_rd_enable, 0);
    check("arst_wr", {bus.vc0_wr_enable, bus.vc1_wr_enable}, 0);
    check("arst_vc_data", bus.vc_data, 0);
    check("arst_flags", {idle_out, active_out, error_out}, 0);
    check("arst_umbral", {umbral_main_out, umbral_vc_out}, 0);
`ifdef VC_DISPATCH_COUNT_EN
    check("arst_counts", {vc0_count, vc1_count}, 0);
`endif
    exp_q.delete();
    wr_ptr = rd_ptr;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); check("post_rst_init", state, 1);
    @(negedge clk); check("post_rst_idle", state, 2);
    check("post_rst_umbral", umbral_main_out, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
